// File: rtl/bid_arb_n.sv
// Credit-based bid arbiter: the highest affordable bid wins, ties are broken round-robin, credits are refilled periodically.
// Latency: grant is registered one cycle after the request is seen in IDLE; each grant is followed by one TURN cycle.
// Backpressure: grant is held until xfr_done, a request drop or MAX_HOLD cycles. Optional starvation override via BID_ARB_STARVE_EN.
module bid_arb_n #(
    parameter int NUM_M        = 4,
    parameter int BID_W        = 16,
    parameter int MAX_CREDIT   = 1000,
    parameter int STARVE_LIMIT = 59,
    parameter int MAX_HOLD     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_M-1:0]           req_valid,
    input  logic [NUM_M*BID_W-1:0]     req_bid,
    input  logic [NUM_M-1:0]           xfr_done,
    input  logic [BID_W-1:0]           refill_amt,
    input  logic [15:0]                refill_interval,
    output logic [NUM_M-1:0]           grant,
    output logic [$clog2(NUM_M)-1:0]   grant_id,
    output logic                       busy,
    output logic [NUM_M*BID_W-1:0]     credit_mon
);

    localparam int IDW = $clog2(NUM_M);
    localparam int CW  = BID_W + 1;
    localparam int HW  = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_CREDIT);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(MAX_HOLD - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]    hold_cnt_q, hold_cnt_d;
    logic [15:0]      refill_cnt_q, refill_cnt_d;
    logic             armed_q, armed_d;
    logic [CW-1:0]    credit_q [NUM_M];
    logic [CW-1:0]    credit_d [NUM_M];

    logic [NUM_M-1:0] elig;
    logic             win_vld;
    logic [IDW-1:0]   win_idx;
    logic [BID_W-1:0] best_bid;
    logic             take;
    logic             refill;
    logic [CW-1:0]    cred;
    int               k;

`ifdef BID_ARB_STARVE_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_LIMIT);
    logic [WW-1:0] wait_cnt_q [NUM_M];
    logic [WW-1:0] wait_cnt_d [NUM_M];

    always_comb begin
        for (int i = 0; i < NUM_M; i++) begin
            if (grant_q[i] || !req_valid[i])
                wait_cnt_d[i] = '0;
            else if (wait_cnt_q[i] != WAIT_MAX)
                wait_cnt_d[i] = wait_cnt_q[i] + WW'(1);
            else
                wait_cnt_d[i] = wait_cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_M; i++) wait_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_M; i++) wait_cnt_q[i] <= wait_cnt_d[i];
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_M; i++)
            elig[i] = req_valid[i] && (req_bid[i*BID_W +: BID_W] != '0) &&
                      ({1'b0, req_bid[i*BID_W +: BID_W]} <= credit_q[i]);
    end

    // Scanning from rr_ptr with a strict '>' leaves the first tied index at/after rr_ptr.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        best_bid = '0;
        k        = 0;
`ifdef BID_ARB_STARVE_EN
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (req_valid[i] && wait_cnt_q[i] == WAIT_MAX) begin
                win_vld = 1'b1;
                win_idx = IDW'(i);
            end
        end
`endif
        if (!win_vld) begin
            for (int j = 0; j < NUM_M; j++) begin
                k = int'(rr_ptr_q) + j;
                if (k >= NUM_M) k = k - NUM_M;
                if (elig[k] && (!win_vld || req_bid[k*BID_W +: BID_W] > best_bid)) begin
                    win_vld  = 1'b1;
                    win_idx  = IDW'(k);
                    best_bid = req_bid[k*BID_W +: BID_W];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        armed_d    = 1'b1;
        take       = 1'b0;
        refill     = (refill_cnt_q >= refill_interval);
        refill_cnt_d = refill ? 16'd0 : refill_cnt_q + 16'd1;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && win_vld) begin
                    take       = 1'b1;
                    grant_d    = NUM_M'(1) << win_idx;
                    state_d    = ST_GRANT;
                    hold_cnt_d = '0;
                    rr_ptr_d   = (win_idx == IDW'(NUM_M - 1)) ? '0 : win_idx + IDW'(1);
                end
            end
            ST_GRANT: begin
                if (|(grant_q & xfr_done) || !(|(grant_q & req_valid)) || hold_cnt_q == HOLD_LAST) begin
                    grant_d    = '0;
                    state_d    = ST_TURN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        // Win is charged before the refill is added, then the sum is capped.
        cred = '0;
        for (int i = 0; i < NUM_M; i++) begin
            cred = credit_q[i];
            if (take && win_idx == IDW'(i))
                cred = (cred > {1'b0, req_bid[i*BID_W +: BID_W]}) ?
                       cred - {1'b0, req_bid[i*BID_W +: BID_W]} : '0;
            if (refill)
                cred = cred + {1'b0, refill_amt};
            if (cred > CREDIT_MAX)
                cred = CREDIT_MAX;
            credit_d[i] = cred;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            hold_cnt_q   <= '0;
            refill_cnt_q <= '0;
            armed_q      <= 1'b0;
            for (int i = 0; i < NUM_M; i++) credit_q[i] <= CREDIT_MAX;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_cnt_q   <= hold_cnt_d;
            refill_cnt_q <= refill_cnt_d;
            armed_q      <= armed_d;
            for (int i = 0; i < NUM_M; i++) credit_q[i] <= credit_d[i];
        end
    end

    always_comb begin
        grant_id = '0;
        for (int i = 0; i < NUM_M; i++)
            if (grant_q[i]) grant_id = IDW'(i);
    end

    always_comb begin
        for (int i = 0; i < NUM_M; i++)
            credit_mon[i*BID_W +: BID_W] = credit_q[i][BID_W-1:0];
    end

    assign grant = grant_q;
    assign busy  = |grant_q;

endmodule

// File: tb/tb_bid_arb_n.sv
// Bench for bid_arb_n: directed scenarios plus randomized traffic, all checked against an
// abstract model (per-master credit/wait arrays, current grantee and phase as plain ints).
module tb_bid_arb_n;

    localparam int NM = 4;
    localparam int BW = 8;
    localparam int MC = 100;
    localparam int SL = 8;
    localparam int MH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NM-1:0]   req_valid = '0;
    logic [NM*BW-1:0] req_bid = '0;
    logic [NM-1:0]   xfr_done = '0;
    logic [BW-1:0]   refill_amt = '0;
    logic [15:0]     refill_interval = 16'd1000;
    logic [NM-1:0]   grant;
    logic [1:0]      grant_id;
    logic            busy;
    logic [NM*BW-1:0] credit_mon;

    bid_arb_n #(.NUM_M(NM), .BID_W(BW), .MAX_CREDIT(MC), .STARVE_LIMIT(SL), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_bid(req_bid), .xfr_done(xfr_done),
        .refill_amt(refill_amt), .refill_interval(refill_interval), .grant(grant),
        .grant_id(grant_id), .busy(busy), .credit_mon(credit_mon)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: m_g is the current grantee (-1 none); m_phase 0=idle 1=granted 2=turn.
    int m_credit [NM];
    int m_wait   [NM];
    int m_g, m_phase, m_held, m_rr, m_rcnt, m_armed;

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int bid_of(input int i);
        return int'(req_bid[i*BW +: BW]);
    endfunction

    function automatic int cred_of(input int i);
        return int'(credit_mon[i*BW +: BW]);
    endfunction

    task automatic set_bid(input int i, input int b);
        req_bid[i*BW +: BW] = BW'(b);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NM; i++) begin
            m_credit[i] = MC;
            m_wait[i]   = 0;
        end
        m_g = -1; m_phase = 0; m_held = 0; m_rr = 0; m_rcnt = 0; m_armed = 0;
    endtask

    task automatic model_step();
        int win, best, bestdist, c;
        bit rf;
        int nc [NM];
        int nw [NM];
        win = -1; best = 0; bestdist = NM;
        if (m_phase == 0 && m_armed != 0) begin
`ifdef BID_ARB_STARVE_EN
            for (int i = NM - 1; i >= 0; i--)
                if (req_valid[i] && m_wait[i] == SL) win = i;
`endif
            if (win < 0) begin
                for (int i = 0; i < NM; i++)
                    if (req_valid[i] && bid_of(i) != 0 && bid_of(i) <= m_credit[i] && bid_of(i) > best)
                        best = bid_of(i);
                for (int i = 0; i < NM; i++)
                    if (best > 0 && req_valid[i] && bid_of(i) == best && bid_of(i) <= m_credit[i]
                        && ((i - m_rr + NM) % NM) < bestdist) begin
                        bestdist = (i - m_rr + NM) % NM;
                        win = i;
                    end
            end
        end
        rf = (m_rcnt >= int'(refill_interval));
        for (int i = 0; i < NM; i++) begin
            c = m_credit[i];
            if (i == win) c = (c - bid_of(i) < 0) ? 0 : c - bid_of(i);
            if (rf) c = c + int'(refill_amt);
            nc[i] = (c > MC) ? MC : c;
            nw[i] = (!req_valid[i] || m_g == i) ? 0 : ((m_wait[i] + 1 > SL) ? SL : m_wait[i] + 1);
        end
        case (m_phase)
            0: if (win >= 0) begin
                   m_g = win; m_phase = 1; m_held = 1; m_rr = (win + 1) % NM;
               end
            1: if (xfr_done[m_g] || !req_valid[m_g] || m_held == MH) begin
                   m_g = -1; m_phase = 2;
               end else begin
                   m_held++;
               end
            default: m_phase = 0;
        endcase
        m_rcnt  = rf ? 0 : m_rcnt + 1;
        m_armed = 1;
        for (int i = 0; i < NM; i++) begin
            m_credit[i] = nc[i];
            m_wait[i]   = nw[i];
        end
    endtask

    task automatic compare_all();
        check("grant", int'(grant), (m_g < 0) ? 0 : (1 << m_g));
        check("grant_id", int'(grant_id), (m_g < 0) ? 0 : m_g);
        check("busy", int'(busy), (m_g < 0) ? 0 : 1);
        for (int i = 0; i < NM; i++) check("credit", cred_of(i), m_credit[i]);
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset(input int interval);
        rst = 1'b0;
        req_valid = '0; req_bid = '0; xfr_done = '0; refill_amt = '0;
        refill_interval = 16'(interval);
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        compare_all();
        rst = 1'b1;
    endtask

    initial begin
        int cnt;
        bit found;

        // Highest bid wins, charged once; release on xfr_done with request drop.
        do_reset(1000);
        req_valid = 4'b1111;
        set_bid(0, 10); set_bid(1, 30); set_bid(2, 20); set_bid(3, 5);
        cycle();
        check("lit_first_edge_no_grant", int'(grant), 0);
        cycle();
        check("lit_grant_m1", int'(grant), 4'b0010);
        check("lit_grant_id_m1", int'(grant_id), 1);
        check("lit_credit1_70", cred_of(1), 70);
        xfr_done = 4'b0010; req_valid = 4'b1101;
        cycle();
        check("lit_turn_grant0", int'(grant), 0);
        xfr_done = '0;
        cycle();
        check("lit_idle_grant0", int'(grant), 0);
        cycle();
        check("lit_grant_m2", int'(grant), 4'b0100);
        check("lit_credit2_80", cred_of(2), 80);

        // Equal bids alternate via round-robin pointer.
        do_reset(1000);
        req_valid = 4'b0011; set_bid(0, 40); set_bid(1, 40);
        cycle(); cycle();
        check("lit_tie_m0", int'(grant), 4'b0001);
        xfr_done = 4'b0001; cycle(); xfr_done = '0; cycle(); cycle();
        check("lit_tie_m1", int'(grant), 4'b0010);
        xfr_done = 4'b0010; cycle(); xfr_done = '0; cycle(); cycle();
        check("lit_tie_m0_again", int'(grant), 4'b0001);
        check("lit_credit0_20", cred_of(0), 20);

        // Unaffordable bid waits for a refill.
        do_reset(40);
        refill_amt = 8'd20;
        req_valid = 4'b0010; set_bid(1, 70);
        cycle(); cycle();
        xfr_done = 4'b0010; cycle(); xfr_done = '0;
        set_bid(1, 50);
        check("lit_credit1_30", cred_of(1), 30);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            cycle();
            if (cred_of(1) == 50) found = 1'b1;
            else check("lit_no_grant_before_refill", int'(busy), 0);
        end
        check("lit_refill_seen", int'(found), 1);
        cycle();
        check("lit_grant_after_refill", int'(grant), 4'b0010);

        // Hold limit, then TURN and a fresh grant.
        do_reset(1000);
        req_valid = 4'b0100; set_bid(2, 10);
        cycle(); cycle();
        cnt = (grant == 4'b0100) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (grant == 4'b0100) cnt++;
            else break;
        end
        check("lit_hold_cycles", cnt, MH);
        check("lit_hold_turn", int'(grant), 0);
        cycle();
        check("lit_hold_idle", int'(grant), 0);
        cycle();
        check("lit_regrant", int'(grant), 4'b0100);

        // Asynchronous reset in the middle of a grant.
        cycle();
        #2 rst = 1'b0;
        #1;
        check("lit_arst_grant", int'(grant), 0);
        check("lit_arst_busy", int'(busy), 0);
        check("lit_arst_gid", int'(grant_id), 0);
        for (int i = 0; i < NM; i++) check("lit_arst_credit", cred_of(i), MC);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cycle();
        check("lit_post_reset_no_grant", int'(grant), 0);
        cycle();
        check("lit_post_reset_grant", int'(grant), 4'b0100);

`ifdef BID_ARB_STARVE_EN
        // A tiny bid is forced through once its wait counter saturates.
        do_reset(0);
        refill_amt = 8'd100;
        req_valid = 4'b1001; set_bid(0, 1); set_bid(3, 90);
        xfr_done = 4'b1000;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            cycle();
            if (grant == 4'b0001) found = 1'b1;
        end
        check("lit_starve_grant", int'(found), 1);
`endif

        // Randomized traffic against the model.
        do_reset(7);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) req_valid = NM'($urandom);
            for (int i = 0; i < NM; i++)
                if ($urandom_range(0, 7) == 0) set_bid(i, $urandom_range(0, 60));
            xfr_done = ($urandom_range(0, 3) == 0) ? NM'($urandom) : '0;
            refill_amt = BW'($urandom_range(0, 25));
            if (n % 500 == 499) refill_interval = 16'($urandom_range(0, 12));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
